// File: rtl/tod_pkg.sv
// Shared constants, FSM states and counter sizing for the TOD event transmitter.
package tod_pkg;

  localparam logic [7:0] EV_SHIFT_ZERO = 8'h70;
  localparam logic [7:0] EV_SHIFT_ONE  = 8'h71;
  localparam logic [7:0] EV_SEC_MARKER = 8'h7D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SHIFT,
    ST_GAP
  } tod_state_e;

  // One spacing counter covers both the start delay and the inter-bit gap.
  function automatic int tod_cnt_w(input int start_delay, input int bit_spacing);
    int m;
    m = (start_delay > bit_spacing) ? start_delay : bit_spacing;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tod_bit_serializer.sv
// Shifts a seconds value out one bit per emit slot, after a start delay and
// with a fixed spacing between bits. A new start restarts it at once.
module tod_bit_serializer
  import tod_pkg::*;
#(
  parameter int W           = 32,
  parameter int START_DELAY = 32,
  parameter int BIT_SPACING = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         bitValid,
  output logic         bitValue,
  output logic         done,
  output logic         nextBit
);

  localparam int CW = tod_cnt_w(START_DELAY, BIT_SPACING);
  localparam int BW = $clog2(W);
  localparam logic [CW-1:0] DLY_INIT = CW'(START_DELAY - 1);
  localparam logic [CW-1:0] GAP_INIT = CW'(BIT_SPACING - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  logic          act_q, act_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] spc_q, spc_d;

  assign bitValid = act_q && (spc_q == '0);
  assign bitValue = MSB_FIRST ? sh_q[W-1] : sh_q[0];
  assign done     = bitValid && (bit_q == LAST_BIT);
  assign nextBit  = act_d && (spc_d == '0);

  always_comb begin
    act_d = act_q;
    sh_d  = sh_q;
    bit_d = bit_q;
    spc_d = spc_q;
    if (start) begin
      act_d = 1'b1;
      sh_d  = value;
      bit_d = '0;
      spc_d = DLY_INIT;
    end else if (bitValid) begin
      sh_d  = MSB_FIRST ? {sh_q[W-2:0], 1'b0} : {1'b0, sh_q[W-1:1]};
      bit_d = bit_q + 1'b1;
      spc_d = GAP_INIT;
      if (done) act_d = 1'b0;
    end else if (act_q) begin
      spc_d = spc_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      sh_q  <= '0;
      bit_q <= '0;
      spc_q <= '0;
    end else begin
      act_q <= act_d;
      sh_q  <= sh_d;
      bit_q <= bit_d;
      spc_q <= spc_d;
    end
  end

endmodule

// File: rtl/tod_event_transmitter.sv
// Emits a seconds marker on PPS followed by the serialised seconds value,
// merging an upstream event stream into the cycles TOD does not use.
module tod_event_transmitter
  import tod_pkg::*;
#(
  parameter int         SECONDS_WIDTH         = 32,
  parameter logic [7:0] EVCODE_SHIFT_ZERO     = EV_SHIFT_ZERO,
  parameter logic [7:0] EVCODE_SHIFT_ONE      = EV_SHIFT_ONE,
  parameter logic [7:0] EVCODE_SECONDS_MARKER = EV_SEC_MARKER,
  parameter int         START_DELAY           = 32,
  parameter int         BIT_SPACING           = 2,
  parameter bit         MSB_FIRST             = 1'b1,
  parameter int         OVERRUN_WIDTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ppsStrobe,
  input  logic [SECONDS_WIDTH-1:0] secondsLoad,
  input  logic                     secondsLoadValid,
  input  logic                     autoIncrement,
  input  logic [7:0]               upEvCode,
  input  logic                     upEvCodeValid,
  output logic                     upEvCodeReady,
  output logic [7:0]               evCode,
  output logic                     evCodeValid,
  output logic [SECONDS_WIDTH-1:0] secondsSent,
  output logic                     busy,
  output logic [OVERRUN_WIDTH-1:0] ppsOverrunCounter
);

  tod_state_e               state_q, state_d;
  logic [SECONDS_WIDTH-1:0] sent_q, sent_d, pend_q, pend_d, frame_val;
  logic                     pend_vld_q, pend_vld_d;
  logic                     busy_q, busy_d;
  logic                     ev_vld_q, ev_vld_d;
  logic [7:0]               ev_code_q, ev_code_d;
  logic [OVERRUN_WIDTH-1:0] ovr_q, ovr_d;
  logic                     bit_valid, bit_value, bit_done, bit_next, up_acc;

  tod_bit_serializer #(
    .W           (SECONDS_WIDTH),
    .START_DELAY (START_DELAY),
    .BIT_SPACING (BIT_SPACING),
    .MSB_FIRST   (MSB_FIRST)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (ppsStrobe),
    .value    (frame_val),
    .bitValid (bit_valid),
    .bitValue (bit_value),
    .done     (bit_done),
    .nextBit  (bit_next)
  );

  // Upstream is held off during reset so nothing is accepted and then lost.
  assign upEvCodeReady = rst_n && !ppsStrobe && !bit_valid;
  assign up_acc        = upEvCodeValid && upEvCodeReady;

  // A load arriving with the PPS wins over an older pending load.
  always_comb begin
    if (secondsLoadValid)   frame_val = secondsLoad;
    else if (pend_vld_q)    frame_val = pend_q;
    else if (autoIncrement) frame_val = sent_q + 1'b1;
    else                    frame_val = sent_q;
  end

  always_comb begin
    state_d    = state_q;
    sent_d     = sent_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovr_d      = ovr_q;
    ev_vld_d   = 1'b0;
    ev_code_d  = 8'h00;
    if (secondsLoadValid) begin
      pend_d     = secondsLoad;
      pend_vld_d = 1'b1;
    end
    if (ppsStrobe) begin
      pend_vld_d = 1'b0;
      sent_d     = frame_val;
      state_d    = bit_next ? ST_SHIFT : ST_DELAY;
      ev_vld_d   = 1'b1;
      ev_code_d  = EVCODE_SECONDS_MARKER;
      if (busy_q && (ovr_q != '1)) ovr_d = ovr_q + 1'b1;
    end else begin
      if (bit_done)                state_d = ST_IDLE;
      else if (bit_next)           state_d = ST_SHIFT;
      else if (state_q == ST_SHIFT) state_d = ST_GAP;
      if (bit_valid) begin
        ev_vld_d  = 1'b1;
        ev_code_d = bit_value ? EVCODE_SHIFT_ONE : EVCODE_SHIFT_ZERO;
      end else if (up_acc) begin
        ev_vld_d  = 1'b1;
        ev_code_d = upEvCode;
      end
    end
    // Stay busy through the cycle that presents the last bit code.
    busy_d = (state_d != ST_IDLE) || bit_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sent_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      ev_vld_q   <= 1'b0;
      ev_code_q  <= 8'h00;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      sent_q     <= sent_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      busy_q     <= busy_d;
      ev_vld_q   <= ev_vld_d;
      ev_code_q  <= ev_code_d;
      ovr_q      <= ovr_d;
    end
  end

  assign evCode            = ev_code_q;
  assign evCodeValid       = ev_vld_q;
  assign secondsSent       = sent_q;
  assign busy              = busy_q;
  assign ppsOverrunCounter = ovr_q;

endmodule
